alu_share_ctrl: RTL

//   Shares one instance of the existing Alu (4-bit aluControl, 32-bit op1/op2, aluOut, isZero) between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 32 +++
 rtl/alu_share_ctrl_arb.sv | 31 +++
 rtl/alu_share_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and sharing-controller state encoding.
// Imported by Alu, rr_arbiter users and alu_share_ctrl.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRA  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } aluOp_t;

  localparam logic [3:0] ALU_OP_LAST = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } shareState_t;

endpackage

// File: rtl/alu.sv
// The shared 32-bit ALU; codes above ALU_OP_LAST return zero.
// Shift amounts are the full op2 value, not truncated.
module Alu
  import alu_pkg::*;
(
  input  logic [3:0]  aluControl,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] aluOut,
  output logic        isZero
);

  always_comb begin
    aluOut = '0;
    case (aluControl)
      ALU_ADD:  aluOut = op1 + op2;
      ALU_SUB:  aluOut = op1 - op2;
      ALU_SLL:  aluOut = op1 << op2;
      ALU_SLT:  aluOut = {31'b0, $signed(op1) < $signed(op2)};
      ALU_SLTU: aluOut = {31'b0, op1 < op2};
      ALU_XOR:  aluOut = op1 ^ op2;
      ALU_SRA:  aluOut = $signed(op1) >>> op2;
      ALU_SRL:  aluOut = op1 >> op2;
      ALU_OR:   aluOut = op1 | op2;
      ALU_AND:  aluOut = op1 & op2;
      default:  aluOut = '0;
    endcase
  end

  assign isZero = (aluOut == 32'b0);

endmodule

// File: rtl/alu_share_ctrl_arb.sv
// Combinational round-robin pick: first request at or after pointer.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grantIdx
);

  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (advance && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grantIdx   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one Alu between NUM_REQ requesters.
// Define ALU_SHARE_ILLEGAL_EN to add the rspIllegal output.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [NUM_REQ-1:0]       reqValid,
  output logic [NUM_REQ-1:0]       reqReady,
  input  logic [NUM_REQ-1:0][3:0]  reqOp,
  input  logic [NUM_REQ-1:0][31:0] reqOp1,
  input  logic [NUM_REQ-1:0][31:0] reqOp2,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [ID_W-1:0]          rspId,
  output logic [31:0]              rspData,
  output logic                     rspZero
`ifdef ALU_SHARE_ILLEGAL_EN
  ,
  output logic                     rspIllegal
`endif
);

  shareState_t state, nxt;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gIdx;
  logic [NUM_REQ-1:0] gnt;
  logic               adv;
  logic               take;

  logic [3:0]      capOp;
  logic [31:0]     capOp1;
  logic [31:0]     capOp2;
  logic [ID_W-1:0] capId;
  logic [31:0]     aluOut;
  logic            isZero;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (reqValid),
    .pointer  (ptr),
    .advance  (adv),
    .grant    (gnt),
    .grantIdx (gIdx)
  );

  Alu u_alu (
    .aluControl (capOp),
    .op1        (capOp1),
    .op2        (capOp2),
    .aluOut     (aluOut),
    .isZero     (isZero)
  );

  // A grant is only possible when no result is waiting or it is leaving.
  always_comb begin
    adv  = 1'b0;
    take = 1'b0;
    nxt  = state;
    unique case (state)
      IDLE: begin
        adv  = 1'b1;
        take = |gnt;
        nxt  = take ? EXEC : IDLE;
      end
      EXEC: nxt = RESP;
      RESP: begin
        adv  = rspReady;
        take = |gnt;
        if (rspReady) nxt = take ? EXEC : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign reqReady = gnt & {NUM_REQ{rstN}};
  assign rspValid = (state == RESP);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      ptr     <= '0;
      capOp   <= '0;
      capOp1  <= '0;
      capOp2  <= '0;
      capId   <= '0;
      rspId   <= '0;
      rspData <= '0;
      rspZero <= 1'b0;
`ifdef ALU_SHARE_ILLEGAL_EN
      rspIllegal <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (take) begin
        capOp  <= reqOp[gIdx];
        capOp1 <= reqOp1[gIdx];
        capOp2 <= reqOp2[gIdx];
        capId  <= gIdx;
        ptr    <= (int'(gIdx) == NUM_REQ - 1) ? '0 : gIdx + 1'b1;
      end
      if (state == EXEC) begin
        rspData <= aluOut;
        rspZero <= isZero;
        rspId   <= capId;
`ifdef ALU_SHARE_ILLEGAL_EN
        rspIllegal <= (capOp > ALU_OP_LAST);
`endif
      end
    end
  end

endmodule
